// File: rtl/enc8to3_seq.sv
// Registered 8-to-3 priority encoder with pending-request capture and a valid/ack handshake.
// The index {a0,a1,a2} (a0 = MSB) holds stable until acknowledged; then that request is retired.
module enc8to3_seq (
  input  logic clk,
  input  logic rst,
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic ack,
  output logic a0,
  output logic a1,
  output logic a2,
  output logic valid,
  output logic ovf
);

  logic [7:0] req;
  logic [7:0] pend_q, pend_d;
  logic [7:0] clr;
  logic [7:0] p;
  logic [2:0] idx_q, idx_d;
  logic [2:0] top;
  logic       valid_q, valid_d;
  logic       ovf_q, ovf_d;
  logic       hs;
  logic       load;

  assign req = {d7, d6, d5, d4, d3, d2, d1, d0};

  always_comb begin
    hs      = valid_q & ack;
    clr     = hs ? (8'b1 << idx_q) : 8'b0;
    p       = pend_q & ~clr;
    // A strobe landing on the bit being retired re-arms it instead of being lost.
    pend_d  = p | req;
    ovf_d   = ovf_q | (|(req & p));
    load    = ~valid_q | hs;

    top = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (p[k]) top = k[2:0];
    end

    valid_d = valid_q;
    idx_d   = idx_q;
    if (load) begin
      valid_d = |p;
      idx_d   = top;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign a0    = idx_q[2];
  assign a1    = idx_q[1];
  assign a2    = idx_q[0];
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: scenario tasks with inline checks, plus a retirement scoreboard
// that pops the expected index each time a valid/ack handshake completes.
module tb_enc8to3_seq;

  logic clk;
  logic rst;
  logic [7:0] d;
  logic ack;
  logic a0, a1, a2, valid, ovf;

  int tests_run;
  int tests_failed;
  int exp_q[$];

  enc8to3_seq dut (
    .clk  (clk),
    .rst  (rst),
    .d0   (d[0]),
    .d1   (d[1]),
    .d2   (d[2]),
    .d3   (d[3]),
    .d4   (d[4]),
    .d5   (d[5]),
    .d6   (d[6]),
    .d7   (d[7]),
    .ack  (ack),
    .a0   (a0),
    .a1   (a1),
    .a2   (a2),
    .valid(valid),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every completed handshake must match the next expected retirement.
  always @(posedge clk) begin
    if (!rst && valid && ack) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL retire_unexpected: got idx %0d, expected none", {a0, a1, a2});
      end else begin
        int e;
        e = exp_q.pop_front();
        if ({29'd0, a0, a1, a2} !== e) begin
          tests_failed++;
          $display("FAIL retire_order: got idx %0d, expected %0d", {a0, a1, a2}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = 8'hFF; ack = 1'b0;
    step(); step();
    tests_run++;
    if ({valid, a0, a1, a2, ovf} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b a=%b%b%b ovf=%b, expected 0 000 0",
               valid, a0, a1, a2, ovf);
    end
    rst = 1'b0;
    step();
    d = 8'h00;
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_latency1: got valid=%b, expected 0", valid);
    end
    step();
    tests_run++;
    if ({valid, a0, a1, a2, ovf} !== 5'b11110) begin
      tests_failed++;
      $display("FAIL reset_first_present: got v=%b a=%b%b%b ovf=%b, expected 1 111 0",
               valid, a0, a1, a2, ovf);
    end
    for (int k = 7; k >= 0; k--) exp_q.push_back(k);
    ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      tests_run++;
      if (valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_no_bubble: got valid=%b at step %0d, expected 1", valid, i);
      end
    end
    step();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got valid=%b left=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_priority();
    d = 8'h25;
    step();
    d = 8'h00;
    step();
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL prio_first: got v=%b a=%b%b%b, expected 1 101", valid, a0, a1, a2);
    end
    exp_q.push_back(5); exp_q.push_back(2); exp_q.push_back(0);
    ack = 1'b1;
    step();
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL prio_second: got v=%b a=%b%b%b, expected 1 010", valid, a0, a1, a2);
    end
    step();
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL prio_third: got v=%b a=%b%b%b, expected 1 000", valid, a0, a1, a2);
    end
    step();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL prio_empty: got valid=%b left=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_hold();
    d = 8'h08;
    step();
    d = 8'h00;
    step();
    d = 8'h40;
    step();
    d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({valid, a0, a1, a2} !== 4'b1011) begin
        tests_failed++;
        $display("FAIL hold_stable: got v=%b a=%b%b%b at %0d, expected 1 011",
                 valid, a0, a1, a2, i);
      end
      step();
    end
    exp_q.push_back(3); exp_q.push_back(6);
    ack = 1'b1;
    step();
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL hold_after_ack: got v=%b a=%b%b%b, expected 1 110", valid, a0, a1, a2);
    end
    step();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_drain: got valid=%b ovf=%b, expected 0 0", valid, ovf);
    end
  endtask

  task automatic test_set_wins();
    d = 8'h10;
    step();
    d = 8'h00;
    step();
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL sw_present: got v=%b a=%b%b%b, expected 1 100", valid, a0, a1, a2);
    end
    exp_q.push_back(4); exp_q.push_back(4);
    ack = 1'b1; d = 8'h10;
    step();
    ack = 1'b0; d = 8'h00;
    // Same-edge strobe is not visible to this load: one-cycle gap, then re-presented.
    tests_run++;
    if (valid !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_gap: got valid=%b ovf=%b, expected 0 0", valid, ovf);
    end
    step();
    tests_run++;
    if ({valid, a0, a1, a2, ovf} !== 5'b11000) begin
      tests_failed++;
      $display("FAIL sw_represent: got v=%b a=%b%b%b ovf=%b, expected 1 100 0",
               valid, a0, a1, a2, ovf);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sw_drain: got valid=%b left=%0d, expected 0 0", valid, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    d = 8'h02;
    step();
    d = 8'h00;
    step();
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_early: got ovf=%b, expected 0", ovf);
    end
    d = 8'h02;
    step();
    d = 8'h00;
    tests_run++;
    if (ovf !== 1'b1 || {valid, a0, a1, a2} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL ovf_set: got ovf=%b v=%b a=%b%b%b, expected 1 1 001",
               ovf, valid, a0, a1, a2);
    end
    exp_q.push_back(1);
    ack = 1'b1;
    step();
    step();
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || ovf !== 1'b1 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got valid=%b ovf=%b left=%0d, expected 0 1 0",
               valid, ovf, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    d = 8'hC2;
    step();
    d = 8'h00;
    step();
    exp_q.push_back(7);
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests_run++;
    if ({valid, a0, a1, a2} !== 4'b1110) begin
      tests_failed++;
      $display("FAIL mid_before_rst: got v=%b a=%b%b%b, expected 1 110", valid, a0, a1, a2);
    end
    rst = 1'b1; d = 8'hFF;
    step();
    rst = 1'b0; d = 8'h00;
    tests_run++;
    if ({valid, a0, a1, a2, ovf} !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_rst_state: got v=%b a=%b%b%b ovf=%b, expected 0 000 0",
               valid, a0, a1, a2, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (valid !== 1'b0 || exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL mid_no_stale: got valid=%b left=%0d at %0d, expected 0 0",
                 valid, exp_q.size(), i);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; d = 8'h00; ack = 1'b0;
    test_reset();
    test_priority();
    test_hold();
    test_set_wins();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
